// File: rtl/timer_task_scheduler_pkg.sv
// timer_task_scheduler_pkg: shared types, defaults and round-robin selection for the task scheduler.
package timer_task_scheduler_pkg;
  typedef enum logic {ST_IDLE, ST_REQ} state_e;
  localparam int CLK_DIV_100US = 5000;
  localparam int PERIOD_W_DFLT = 16;
  // First set bit at or after (last+1) mod n, wrapping; returns last when nothing is pending.
  function automatic int rr_pick(input logic [7:0] pend, input int last, input int n);
    int sel;
    int idx;
    sel = last;
    for (int i = n; i >= 1; i--) begin
      idx = (last + i) % n;
      if (pend[idx[2:0]]) sel = idx;
    end
    return sel;
  endfunction
endpackage

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: prescaler emitting a one-cycle tick every CLK_DIV clocks.
module timer_tick_gen #(
  parameter int CLK_DIV = 5000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(CLK_DIV - 1);
  always_comb cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/timer_task_scheduler.sv
// timer_task_scheduler: tick-based periodic channels granted round-robin to one executor via req/ack.
module timer_task_scheduler
  import timer_task_scheduler_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_100US,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = PERIOD_W_DFLT,
  parameter int ID_W     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       tick_o,
  input  logic [NUM_CH-1:0]          ch_en_i,
  input  logic [NUM_CH*PERIOD_W-1:0] ch_period_i,
  output logic                       task_req_o,
  output logic [ID_W-1:0]            task_id_o,
  input  logic                       task_ack_i,
  output logic [NUM_CH-1:0]          overrun_o,
  input  logic [NUM_CH-1:0]          overrun_clr_i
);
  logic                tick;
  logic [PERIOD_W-1:0] period [NUM_CH];
  logic [PERIOD_W-1:0] cnt_q [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   act, fire, done;
  logic [NUM_CH-1:0]   pend_q, pend_d, ovr_q, ovr_d;
  state_e              st_q, st_d;
  logic [ID_W-1:0]     id_q, id_d, last_q, last_d;

  timer_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign period[n] = ch_period_i[n*PERIOD_W +: PERIOD_W];
    assign act[n]    = ch_en_i[n] && period[n] != '0;
  end

  // An ack retiring a channel in the same edge it fires keeps it pending without an overrun.
  always_comb begin
    fire = '0;
    done = '0;
    pend_d = '0;
    ovr_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n] = period[n];
      fire[n] = act[n] && tick && cnt_q[n] <= PERIOD_W'(1);
      done[n] = st_q == ST_REQ && task_ack_i && id_q == ID_W'(n);
      cnt_d[n] = !act[n] ? period[n] : !tick ? cnt_q[n] : fire[n] ? period[n] : cnt_q[n] - PERIOD_W'(1);
      pend_d[n] = !act[n] ? 1'b0 : fire[n] ? 1'b1 : done[n] ? 1'b0 : pend_q[n];
      ovr_d[n] = (fire[n] && pend_q[n] && !done[n]) || (ovr_q[n] && !overrun_clr_i[n]);
    end
  end

  always_comb begin
    st_d = st_q;
    id_d = id_q;
    last_d = last_q;
    if (st_q == ST_IDLE && |pend_q) begin
      st_d = ST_REQ;
      id_d = ID_W'(rr_pick(8'(pend_q), int'(last_q), NUM_CH));
    end else if (st_q == ST_REQ && task_ack_i) begin
      st_d = ST_IDLE;
      last_d = id_q;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < NUM_CH; n++) cnt_q[n] <= rst_i ? '0 : cnt_d[n];
    pend_q <= rst_i ? '0 : pend_d;
    ovr_q  <= rst_i ? '0 : ovr_d;
    st_q   <= rst_i ? ST_IDLE : st_d;
    id_q   <= rst_i ? '0 : id_d;
    last_q <= rst_i ? '0 : last_d;
  end

  assign tick_o     = tick;
  assign task_req_o = st_q == ST_REQ;
  assign task_id_o  = id_q;
  assign overrun_o  = ovr_q;
endmodule

// File: tb/tb_timer_task_scheduler.sv
// tb_timer_task_scheduler: randomized and directed stimulus checked every cycle against a behavioural model.
module tb_timer_task_scheduler;
  localparam int D = 10;
  localparam int N = 4;
  localparam int PW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic [N-1:0] en;
  logic [N*PW-1:0] per;
  logic req;
  logic [IW-1:0] id;
  logic ack;
  logic [N-1:0] ovr;
  logic [N-1:0] clr;

  always #5 clk = ~clk;

  timer_task_scheduler #(.CLK_DIV(D), .NUM_CH(N), .PERIOD_W(PW), .ID_W(IW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tick_o        (tick),
    .ch_en_i       (en),
    .ch_period_i   (per),
    .task_req_o    (req),
    .task_id_o     (id),
    .task_ack_i    (ack),
    .overrun_o     (ovr),
    .overrun_clr_i (clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  int k;
  int rem [N];
  bit pend [N];
  bit ovr_m [N];
  bit busy;
  int gid;
  int last;
  int mode;
  int age;

  function automatic bit tick_now();
    return (k % D) == D - 1;
  endfunction

  function automatic logic [N-1:0] ovr_vec();
    logic [N-1:0] v;
    for (int n = 0; n < N; n++) v[n] = ovr_m[n];
    return v;
  endfunction

  task automatic model_step();
    bit tk, acc, fire, dn, anyp;
    int og, nx, p;
    if (rst) begin
      k = 0; busy = 0; gid = 0; last = 0;
      for (int n = 0; n < N; n++) begin rem[n] = 0; pend[n] = 0; ovr_m[n] = 0; end
      return;
    end
    tk = tick_now();
    acc = busy && ack;
    og = gid;
    anyp = 0;
    for (int n = 0; n < N; n++) anyp |= pend[n];
    if (!busy && anyp) begin
      busy = 1;
      for (int s = 1; s <= N; s++) begin
        nx = (last + s) % N;
        if (pend[nx]) begin gid = nx; break; end
      end
    end else if (acc) begin
      busy = 0;
      last = og;
    end
    for (int n = 0; n < N; n++) begin
      p = int'(per[n*PW +: PW]);
      dn = acc && og == n;
      fire = 0;
      if (en[n] && p != 0 && tk) begin
        if (rem[n] <= 1) begin fire = 1; rem[n] = p; end
        else rem[n] = rem[n] - 1;
      end
      if (fire && pend[n] && !dn) ovr_m[n] = 1;
      else if (clr[n]) ovr_m[n] = 0;
      if (!en[n] || p == 0) begin rem[n] = p; pend[n] = 0; end
      else if (fire) pend[n] = 1;
      else if (dn) pend[n] = 0;
    end
    k++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick", tick, tick_now());
    check("req", req, busy);
    check("id", id, gid);
    check("ovr", ovr, ovr_vec());
    age = busy ? age + 1 : 0;
    case (mode)
      0: ack = $urandom_range(0, 3) == 0;
      1: ack = busy && age >= 2;
      2: ack = busy && age >= 3;
      4: ack = busy && tick_now();
      default: ack = 1'b0;
    endcase
    clr = (mode == 0 && $urandom_range(0, 7) == 0) ? N'($urandom) : '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic first_tick(input string tag);
    int c;
    c = 0;
    do begin cycle(); c++; end while (!tick && c < 3 * D);
    check(tag, c, D - 1);
  endtask

  task automatic set_per(input int n, input int p);
    per[n*PW +: PW] = PW'(p);
  endtask

  initial begin
    int c;
    rst = 1'b1; en = '0; per = '0; ack = 1'b0; clr = '0; mode = 3; age = 0;
    do_reset();
    first_tick("first_tick");
    repeat (3 * D) cycle();

    do_reset();
    mode = 1;
    set_per(0, 3);
    cycle();
    en = 4'b0001;
    repeat (12 * D) cycle();

    do_reset();
    mode = 2;
    for (int n = 0; n < N; n++) set_per(n, 1);
    cycle();
    en = 4'b1111;
    repeat (20 * D) cycle();

    do_reset();
    mode = 3;
    per = '0;
    set_per(1, 1);
    cycle();
    en = 4'b0010;
    repeat (3 * D) cycle();
    check("ovr1_set", ovr[1], 1'b1);
    while ((k % D) != 2) cycle();
    clr = 4'b0010;
    cycle();
    check("ovr1_clr", ovr[1], 1'b0);
    while (!tick_now()) cycle();
    clr = 4'b0010;
    cycle();
    check("ovr1_set_wins", ovr[1], 1'b1);
    mode = 1;
    repeat (4 * D) cycle();

    do_reset();
    mode = 4;
    per = '0;
    set_per(2, 1);
    cycle();
    en = 4'b0100;
    repeat (8 * D) cycle();
    check("ovr2_coincide", ovr[2], 1'b0);

    do_reset();
    mode = 3;
    set_per(0, 1);
    cycle();
    en = 4'b0001;
    c = 0;
    while (!req && c < 4 * D) begin cycle(); c++; end
    check("wait_req", req, 1'b1);
    rst = 1'b1;
    cycle();
    check("rst_req", req, 1'b0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    en = '0;
    first_tick("tick_after_rst");

    mode = 0;
    for (int r = 0; r < 30; r++) begin
      en = N'($urandom);
      for (int n = 0; n < N; n++) set_per(n, $urandom_range(0, 4));
      repeat ($urandom_range(20, 80)) cycle();
      if (r % 7 == 3) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_task_scheduler.md
Name: timer_task_scheduler

Overview:
- Periodic task scheduler built on a 100 us system tick.
- Divides clk_i into a one-cycle tick strobe and runs NUM_CH independent programmable-period channels counted in ticks.
- Due channels are queued and granted one at a time, round-robin, to a single shared task executor via a req/ack handshake.
- Sits between the board clock and the periodic housekeeping logic, for example sampling and status refresh.

Parameters:
- CLK_DIV, 5000: clk_i cycles per tick (100 us at 50 MHz); must be >= 2.
- NUM_CH, 4: number of scheduled channels, 2..8.
- PERIOD_W, 16: width of each channel period, in ticks.
- ID_W, 2: width of task_id_o; must be >= clog2(NUM_CH).

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous reset, active-high.
- tick_o, output, 1: one-cycle strobe every CLK_DIV cycles.
- ch_en_i, input, NUM_CH: per-channel enable.
- ch_period_i, input, NUM_CH*PERIOD_W: per-channel period in ticks; channel n uses bits [n*PERIOD_W +: PERIOD_W].
- task_req_o, output, 1: a task is due and presented to the executor.
- task_id_o, output, ID_W: channel index being requested.
- task_ack_i, input, 1: executor accepts the current request.
- overrun_o, output, NUM_CH: sticky per-channel overrun flags.
- overrun_clr_i, input, NUM_CH: per-channel clear for overrun_o.

Behaviour:
- Reset. rst_i is sampled on the clk_i edge. All outputs are 0 on the cycle after reset is asserted: tick_o, task_req_o, task_id_o, overrun_o. Prescaler, channel counters, pending bits and round-robin pointer are also cleared. Reset applied mid-handshake drops task_req_o immediately; no ack is expected afterwards.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick_o=1 exactly in the cycle where count==CLK_DIV-1.
  - The first tick after reset occurs on cycle CLK_DIV.
- Channel counter (cnt[n], PERIOD_W bits):
  - Disabled (ch_en_i[n]=0) or period==0: cnt is loaded with the period value, pending[n] is cleared, the channel never fires, and overrun_o[n] is untouched.
  - Enabled with period P>0: on each tick, if cnt<=1 the channel fires and cnt reloads P; otherwise cnt decrements by 1.
  - First fire therefore occurs on the P-th tick after enable. With P=1 the channel fires on every tick.
  - A period change while enabled takes effect at the next reload.
- Fire handling:
  - A fire sets pending[n] on the same edge.
  - If pending[n] was already 1 and is not being cleared by an ack that cycle, overrun_o[n] is set.
  - If fire and clear of the same channel coincide, pending stays 1 with no overrun.
  - If overrun_clr_i[n] and a new overrun coincide, the flag ends up set (set wins).
- Arbiter FSM, with states IDLE and REQ:
  - IDLE: if any pending bit is set, select the lowest index at or above (last_grant+1) mod NUM_CH, wrapping. Register task_id_o, drive task_req_o=1 and go to REQ.
  - REQ: task_req_o and task_id_o are held stable until task_ack_i=1. On ack, clear pending[task_id_o], update last_grant, drop task_req_o on the next edge and return to IDLE.
  - There is at least one idle cycle between consecutive requests.
  - task_ack_i is ignored in IDLE.
  - A request is never retracted, even if its channel is disabled while in REQ; the ack still completes it normally.
- Latency: a fire on tick cycle T, with the FSM idle, gives task_req_o=1 at cycle T+2.

Decomposition:
- Shared package holds:
  - the FSM state enum {ST_IDLE, ST_REQ};
  - the default constants CLK_DIV_100US=5000 and PERIOD_W_DFLT=16;
  - a round-robin priority-select function.
- One sub-module: timer_tick_gen (prescaler producing tick_o), parameterised by CLK_DIV.
- Channel counters and the arbiter stay in the top level.

Test Plan:
- Prescaler, CLK_DIV=10 for simulation: release reset -> tick_o pulses at cycles 10, 20, 30, each exactly one cycle wide.
- Single channel: ch0 enabled, P=3, executor acks one cycle after req -> requests with id 0 on ticks 3, 6, 9; task_req_o rises 2 cycles after each tick; overrun_o=0.
- Round-robin: ch0..3 all enabled with P=1, ack delayed 2 cycles -> grants in order 0,1,2,3,0,…; no channel is granted twice while another is pending.
- Overrun: ch1 P=1, ack withheld for 3 ticks -> overrun_o[1]=1 after the second tick. Pulsing overrun_clr_i[1] clears it. Pulsing it in the same cycle as a new overrun leaves it set.
- Coincidence: ack of ch2 lands in the same cycle that ch2 fires -> pending[2] stays set, overrun_o[2]=0, and a new request for id 2 follows.
- Reset mid-REQ: assert rst_i while task_req_o=1 -> next cycle task_req_o=0, pending=0, overrun_o=0, and the prescaler restarts so the first tick comes CLK_DIV cycles after release.
